// File: rtl/pwm_audio_dac_if.sv
// Sample handshake between the mixer (master) and the PWM DAC sink (slave).
interface pwm_audio_dac_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] sample_in;
    logic             sample_valid;
    logic             sample_ready;

    modport master (output sample_in, output sample_valid, input sample_ready);
    modport slave  (input sample_in, input sample_valid, output sample_ready);
endinterface

// File: rtl/pwm_audio_dac.sv
// 1-bit PWM audio sink with a one-entry sample buffer; duty updates only at period boundaries.
// Optional macro PWM_UNDERRUN_COUNT_EN adds a saturating 8-bit underrun_count output.
module pwm_audio_dac #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    pwm_audio_dac_if.slave        smp,
    output logic                  pwm_out,
    output logic                  period_start,
    output logic                  underrun
`ifdef PWM_UNDERRUN_COUNT_EN
    ,
    output logic [7:0]            underrun_count
`endif
);

    localparam int unsigned     PW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;

    logic [PW-1:0]    presc_cnt;
    logic [WIDTH-1:0] pwm_cnt;
    logic [WIDTH-1:0] duty;
    logic [WIDTH-1:0] hold_reg;
    logic             hold_full;

    logic tick_c;
    logic boundary_c;
    logic accept_c;

    always_comb begin
        tick_c     = enable && (presc_cnt == PRESC_MAX);
        boundary_c = tick_c && (pwm_cnt == CNT_MAX);
        accept_c   = smp.sample_valid && !hold_full;
    end

    assign smp.sample_ready = ~hold_full;

    // Prescaler and PWM counter; both held at zero while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
        end else if (!enable) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
        end else begin
            presc_cnt <= tick_c ? '0 : presc_cnt + PW'(1);
            if (tick_c) begin
                pwm_cnt <= pwm_cnt + WIDTH'(1);
            end
        end
    end

    // Accept and boundary-load are mutually exclusive: accept needs an empty buffer, load a full one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg  <= '0;
            hold_full <= 1'b0;
            duty      <= '0;
        end else if (accept_c) begin
            hold_reg  <= smp.sample_in;
            hold_full <= 1'b1;
        end else if (boundary_c && hold_full) begin
            duty      <= hold_reg;
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            pwm_out      <= enable && (pwm_cnt < duty);
            period_start <= boundary_c;
            underrun     <= boundary_c && !hold_full;
        end
    end

`ifdef PWM_UNDERRUN_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_count <= '0;
        end else if (boundary_c && !hold_full && (underrun_count != 8'hFF)) begin
            underrun_count <= underrun_count + 8'd1;
        end
    end
`endif

endmodule
